// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: gap timing, hole selection, hit window, scoring and VGA draw handshake.
// Optional build macro: MOLE_WRONG_HIT_PENALTY_EN (a pulse on a non-active hole during UP counts as a miss).
module mole_round_scheduler #(
  parameter int          MOLE_UP_TICKS = 750,
  parameter int          GAP_TICKS     = 250,
  parameter int          ROUND_MOLES   = 30,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] hit,
  input  logic       draw_ack,
  output logic       draw_req,
  output logic [1:0] draw_pos,
  output logic       draw_show,
  output logic [3:0] mole_up,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic [7:0] moles_left,
  output logic       busy,
  output logic       done
);

  localparam int CNT_MAX = (MOLE_UP_TICKS > GAP_TICKS) ? MOLE_UP_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] UP_LOAD    = CNT_W'(MOLE_UP_TICKS);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);
  localparam logic [7:0]       ROUND_LOAD = 8'(ROUND_MOLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SHOW,
    ST_UP,
    ST_HIDE,
    ST_DONE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       lfsr_reg;
  logic [1:0]       prev_hole_reg;

  logic             lfsr_fb;
  logic [1:0]       pick_raw;
  logic [1:0]       pick_pos;
  logic [3:0]       pos_onehot;
  logic             hit_active;
  logic             cnt_is_last;
  logic             miss_expire;
  logic             miss_wrong;
  logic [8:0]       misses_sum;
  logic [7:0]       misses_sat;
  logic [7:0]       score_sat;

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_fb  = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign pick_raw = lfsr_reg[1:0];
  // Never reuse the hole of the mole that just left
  assign pick_pos = (pick_raw == prev_hole_reg) ? pick_raw + 2'd1 : pick_raw;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hole
      assign pos_onehot[gi] = (draw_pos == 2'(gi));
    end
  endgenerate

  assign hit_active  = |(hit & pos_onehot);
  assign cnt_is_last = (cnt_reg == CNT_LAST);
  assign miss_expire = (state_reg == ST_UP) && !hit_active && tick && cnt_is_last;

`ifdef MOLE_WRONG_HIT_PENALTY_EN
  logic hit_wrong;
  assign hit_wrong  = |(hit & ~pos_onehot);
  assign miss_wrong = (state_reg == ST_UP) && hit_wrong;
`else
  assign miss_wrong = 1'b0;
`endif

  assign misses_sum = {1'b0, misses} + {8'd0, miss_expire} + {8'd0, miss_wrong};
  assign misses_sat = misses_sum[8] ? 8'hFF : misses_sum[7:0];
  assign score_sat  = (score == 8'hFF) ? score : score + 8'd1;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      lfsr_reg      <= LFSR_SEED;
      prev_hole_reg <= '0;
      draw_req      <= 1'b0;
      draw_pos      <= '0;
      draw_show     <= 1'b0;
      mole_up       <= '0;
      score         <= '0;
      misses        <= '0;
      moles_left    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            score      <= '0;
            misses     <= '0;
            moles_left <= ROUND_LOAD;
            cnt_reg    <= GAP_LOAD;
            draw_pos   <= '0;
            draw_show  <= 1'b0;
            draw_req   <= 1'b0;
            mole_up    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state_reg  <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (tick) begin
            if (cnt_is_last) begin
              draw_pos      <= pick_pos;
              prev_hole_reg <= pick_pos;
              draw_show     <= 1'b1;
              draw_req      <= 1'b1;
              state_reg     <= ST_SHOW;
            end else begin
              cnt_reg <= cnt_reg - CNT_LAST;
            end
          end
        end

        ST_SHOW: begin
          // Ticks are frozen here so the VGA path can stall without eating mole time
          if (draw_ack) begin
            draw_req  <= 1'b0;
            mole_up   <= pos_onehot;
            cnt_reg   <= UP_LOAD;
            state_reg <= ST_UP;
          end
        end

        ST_UP: begin
          misses <= misses_sat;
          if (hit_active || (tick && cnt_is_last)) begin
            if (hit_active) begin
              score <= score_sat;
            end
            mole_up   <= '0;
            draw_show <= 1'b0;
            draw_req  <= 1'b1;
            state_reg <= ST_HIDE;
          end else if (tick) begin
            cnt_reg <= cnt_reg - CNT_LAST;
          end
        end

        ST_HIDE: begin
          if (draw_ack) begin
            draw_req   <= 1'b0;
            moles_left <= moles_left - 8'd1;
            if (moles_left == 8'd1) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              cnt_reg   <= GAP_LOAD;
              state_reg <= ST_GAP;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler: per-cycle vector table plus hand sequences for stall and reset.
`timescale 1ns/1ps
module tb_mole_round_scheduler;

  localparam int         UP_T  = 4;
  localparam int         GAP_T = 2;
  localparam int         MOLES = 3;
  localparam logic [7:0] SEED  = 8'hA5;
`ifdef MOLE_WRONG_HIT_PENALTY_EN
  localparam logic [7:0] P = 8'd1;
`else
  localparam logic [7:0] P = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [3:0] hit = 4'd0;
  logic       draw_ack = 1'b0;
  logic       draw_req;
  logic [1:0] draw_pos;
  logic       draw_show;
  logic [3:0] mole_up;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] moles_left;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  mole_round_scheduler #(
    .MOLE_UP_TICKS(UP_T),
    .GAP_TICKS    (GAP_T),
    .ROUND_MOLES  (MOLES),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .tick      (tick),
    .start     (start),
    .hit       (hit),
    .draw_ack  (draw_ack),
    .draw_req  (draw_req),
    .draw_pos  (draw_pos),
    .draw_show (draw_show),
    .mole_up   (mole_up),
    .score     (score),
    .misses    (misses),
    .moles_left(moles_left),
    .busy      (busy),
    .done      (done)
  );

  // Reference LFSR; m_lfsr_used is the value the design saw at the most recent edge
  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_used;
  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr      <= SEED;
      m_lfsr_used <= SEED;
    end else begin
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_lfsr_used <= m_lfsr;
    end
  end

  // hmode: 0 none, 1 active hole, 2 wrong hole, 3 active+wrong, 4 all holes
  typedef struct {
    bit         start;
    int         hmode;
    bit         req;
    bit         show;
    bit         up;
    bit         busy;
    bit         dn;
    logic [7:0] sc;
    logic [7:0] ms;
    logic [7:0] left;
  } vec_t;

  vec_t       tbl[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] cur_pos = 2'd0;
  logic [1:0] m_prev = 2'd0;
  logic [1:0] last_pos = 2'd0;
  bit         have_last = 1'b0;
  logic [3:0] one_hot_base = 4'b0001;

  task automatic add(input bit s, input int hm, input bit rq, input bit sh, input bit up,
                     input bit bz, input bit dn, input int sc, input int ms, input int left);
    vec_t v;
    v.start = s;  v.hmode = hm; v.req = rq; v.show = sh; v.up = up;
    v.busy = bz;  v.dn = dn;    v.sc = 8'(sc); v.ms = 8'(ms); v.left = 8'(left);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit s, input bit t, input bit a, input logic [3:0] h);
    @(negedge clk);
    start = s; tick = t; draw_ack = a; hit = h;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] p);
    return one_hot_base << p;
  endfunction

  function automatic logic [3:0] hit_vec(input int hm);
    logic [1:0] wp;
    wp = cur_pos + 2'd1;
    case (hm)
      1:       return onehot(cur_pos);
      2:       return onehot(wp);
      3:       return onehot(cur_pos) | onehot(wp);
      4:       return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // Called right after the edge that moved GAP->SHOW
  task automatic new_show();
    cur_pos = m_lfsr_used[1:0];
    if (cur_pos == m_prev) cur_pos = cur_pos + 2'd1;
    m_prev = cur_pos;
    chk("draw_pos", 32'(draw_pos), 32'(cur_pos));
    if (have_last) chk("distinct_hole", 32'(draw_pos == last_pos), 32'd0);
    last_pos  = draw_pos;
    have_last = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 200us");
    $fatal(1);
  end

  initial begin
    int  round_a_len;
    int  req_pulses;
    bit  prev_req;
    bit  seen_req;

    // ---- round A: no hits; stray start/hit pulses outside UP are ignored
    add(1,0, 0,0,0,1,0, 0,0,3);
    add(0,4, 0,0,0,1,0, 0,0,3);
    add(0,0, 1,1,0,1,0, 0,0,3);
    add(0,4, 0,1,1,1,0, 0,0,3);
    add(0,0, 0,1,1,1,0, 0,0,3);
    add(1,0, 0,1,1,1,0, 0,0,3);
    add(0,0, 0,1,1,1,0, 0,0,3);
    add(0,0, 1,0,0,1,0, 0,1,3);
    add(0,4, 0,0,0,1,0, 0,1,2);
    add(0,0, 0,0,0,1,0, 0,1,2);
    add(0,0, 1,1,0,1,0, 0,1,2);
    for (int k = 0; k < 4; k++) add(0,0, 0,1,1,1,0, 0,1,2);
    add(0,0, 1,0,0,1,0, 0,2,2);
    add(0,0, 0,0,0,1,0, 0,2,1);
    add(0,0, 0,0,0,1,0, 0,2,1);
    add(0,0, 1,1,0,1,0, 0,2,1);
    for (int k = 0; k < 4; k++) add(0,0, 0,1,1,1,0, 0,2,1);
    add(0,0, 1,0,0,1,0, 0,3,1);
    add(0,0, 0,0,0,0,1, 0,3,0);
    add(0,4, 0,0,0,0,1, 0,3,0);
    round_a_len = tbl.size();
    // ---- round B: correct hit on the second UP cycle of every mole
    for (int m = 0; m < 3; m++) begin
      if (m == 0) begin
        add(1,0, 0,0,0,1,0, 0,0,3);
        add(0,0, 0,0,0,1,0, 0,0,3);
      end
      add(0,0, 1,1,0,1,0, m,0,3-m);
      add(0,0, 0,1,1,1,0, m,0,3-m);
      add(0,0, 0,1,1,1,0, m,0,3-m);
      add(0,1, 1,0,0,1,0, m+1,0,3-m);
      if (m < 2) begin
        add(0,0, 0,0,0,1,0, m+1,0,2-m);
        add(0,0, 0,0,0,1,0, m+1,0,2-m);
      end else begin
        add(0,0, 0,0,0,0,1, 3,0,0);
      end
    end
    // ---- round C: hit on expiry tick, wrong-hole pulse, correct+wrong together
    add(1,0, 0,0,0,1,0, 0,0,3);
    add(0,0, 0,0,0,1,0, 0,0,3);
    add(0,0, 1,1,0,1,0, 0,0,3);
    for (int k = 0; k < 4; k++) add(0,0, 0,1,1,1,0, 0,0,3);
    add(0,1, 1,0,0,1,0, 1,0,3);
    add(0,0, 0,0,0,1,0, 1,0,2);
    add(0,0, 0,0,0,1,0, 1,0,2);
    add(0,0, 1,1,0,1,0, 1,0,2);
    add(0,0, 0,1,1,1,0, 1,0,2);
    add(0,2, 0,1,1,1,0, 1,P,2);
    add(0,0, 0,1,1,1,0, 1,P,2);
    add(0,0, 0,1,1,1,0, 1,P,2);
    add(0,0, 1,0,0,1,0, 1,P+1,2);
    add(0,0, 0,0,0,1,0, 1,P+1,1);
    add(0,0, 0,0,0,1,0, 1,P+1,1);
    add(0,0, 1,1,0,1,0, 1,P+1,1);
    add(0,0, 0,1,1,1,0, 1,P+1,1);
    add(0,3, 1,0,0,1,0, 2,2*P+1,1);
    add(0,0, 0,0,0,0,1, 2,2*P+1,0);

    // ---- reset state
    #1 Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_draw_req",   32'(draw_req),   32'd0);
    chk("rst_draw_pos",   32'(draw_pos),   32'd0);
    chk("rst_draw_show",  32'(draw_show),  32'd0);
    chk("rst_mole_up",    32'(mole_up),    32'd0);
    chk("rst_score",      32'(score),      32'd0);
    chk("rst_misses",     32'(misses),     32'd0);
    chk("rst_moles_left", 32'(moles_left), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    @(negedge clk);
    Reset = 1'b0;

    // ---- table: tick every cycle, draw_ack tied high
    prev_req   = 1'b0;
    seen_req   = 1'b0;
    req_pulses = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      step(v.start, 1'b1, 1'b1, hit_vec(v.hmode));
      $display("vec %0d: req=%b show=%b pos=%0d up=%b busy=%b done=%b score=%0d misses=%0d left=%0d",
               i, draw_req, draw_show, draw_pos, mole_up, busy, done, score, misses, moles_left);
      chk("draw_req",   32'(draw_req),   32'(v.req));
      chk("draw_show",  32'(draw_show),  32'(v.show));
      chk("busy",       32'(busy),       32'(v.busy));
      chk("done",       32'(done),       32'(v.dn));
      chk("score",      32'(score),      32'(v.sc));
      chk("misses",     32'(misses),     32'(v.ms));
      chk("moles_left", 32'(moles_left), 32'(v.left));
      if (v.req && v.show && !prev_req) new_show();
      chk("mole_up", 32'(mole_up), v.up ? 32'(onehot(cur_pos)) : 32'd0);
      if (i < round_a_len && draw_req && !seen_req) req_pulses++;
      seen_req = draw_req;
      prev_req = v.req;
      if (i == round_a_len - 1) chk("round_a_req_pulses", 32'(req_pulses), 32'd6);
    end

    // ---- draw_ack held low for 10 cycles in SHOW
    step(1'b1, 1'b1, 1'b0, 4'h0);
    $display("stall: start accepted busy=%b", busy);
    chk("stall_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    chk("stall_req_rise", 32'(draw_req), 32'd1);
    chk("stall_show",     32'(draw_show), 32'd1);
    new_show();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0);
      $display("stall cycle %0d: req=%b pos=%0d up=%b", k, draw_req, draw_pos, mole_up);
      chk("stall_req_held", 32'(draw_req), 32'd1);
      chk("stall_pos_held", 32'(draw_pos), 32'(cur_pos));
      chk("stall_mole_up0", 32'(mole_up),  32'd0);
    end
    step(1'b0, 1'b1, 1'b1, 4'h0);
    $display("stall: ack taken req=%b up=%b", draw_req, mole_up);
    chk("ack_mole_up",  32'(mole_up),  32'(onehot(cur_pos)));
    chk("ack_req_fall", 32'(draw_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0);
      chk("up_still", 32'(mole_up), 32'(onehot(cur_pos)));
    end

    // ---- asynchronous reset in the middle of UP
    #2 Reset = 1'b1;
    #1;
    $display("mid-UP reset: busy=%b up=%b req=%b", busy, mole_up, draw_req);
    chk("mid_rst_busy",    32'(busy),     32'd0);
    chk("mid_rst_mole_up", 32'(mole_up),  32'd0);
    chk("mid_rst_req",     32'(draw_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    Reset     = 1'b0;
    m_prev    = 2'd0;
    have_last = 1'b0;
    step(1'b1, 1'b1, 1'b1, 4'h0);
    $display("restart: busy=%b score=%0d left=%0d", busy, score, moles_left);
    chk("restart_busy",  32'(busy),       32'd1);
    chk("restart_score", 32'(score),      32'd0);
    chk("restart_left",  32'(moles_left), 32'd3);
    chk("restart_miss",  32'(misses),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
